// File: rtl/riscv_pkg.sv
// Shared RISC-V instruction types, opcode constants and the encode/legality helpers
// used by the instruction encoder pipeline.
package riscv;

  localparam int unsigned INSN_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;
  localparam int unsigned IMM_W  = 20;

  typedef logic [INSN_W-1:0] insn_t;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5,
    UNDEF  = 3'd7
  } insn_type_t;

  // imm holds imm[11:0] for I/S, off[12:1] for B, off[20:1] for J, insn[31:12] for U
  typedef struct packed {
    insn_type_t       itype;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [F3_W-1:0]  funct3;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [F7_W-1:0]  funct7;
    logic [IMM_W-1:0] imm;
  } insn_info_t;

  typedef struct packed {
    insn_info_t info;
    logic       err;
  } s1_payload_t;

  typedef struct packed {
    insn_t insn;
    logic  err;
  } s2_payload_t;

  localparam logic [OPC_W-1:0] OP_IMM = 7'h13;
  localparam logic [OPC_W-1:0] OP     = 7'h33;
  localparam logic [OPC_W-1:0] STORE  = 7'h23;
  localparam logic [OPC_W-1:0] BRANCH = 7'h63;
  localparam logic [OPC_W-1:0] JAL    = 7'h6F;
  localparam logic [OPC_W-1:0] LUI    = 7'h37;

  // Bit-pack decoded fields into the architectural instruction word
  function automatic insn_t encode_insn(input insn_info_t info);
    insn_t w;
    w = '0;
    case (info.itype)
      R_TYPE: w = {info.funct7, info.rs2, info.rs1, info.funct3, info.rd, info.opcode};
      I_TYPE: w = {info.imm[11:0], info.rs1, info.funct3, info.rd, info.opcode};
      S_TYPE: w = {info.imm[11:5], info.rs2, info.rs1, info.funct3, info.imm[4:0], info.opcode};
      B_TYPE: w = {info.imm[11], info.imm[9:4], info.rs2, info.rs1, info.funct3,
                   info.imm[3:0], info.imm[10], info.opcode};
      U_TYPE: w = {info.imm, info.rd, info.opcode};
      J_TYPE: w = {info.imm[19], info.imm[9:0], info.imm[10], info.imm[18:11],
                   info.rd, info.opcode};
      default: w = '0;
    endcase
    return w;
  endfunction

  // 12-bit immediates must sign-extend cleanly from bit 11
  function automatic logic insn_illegal(input insn_info_t info);
    logic imm12;
    imm12 = (info.itype == I_TYPE) || (info.itype == S_TYPE) || (info.itype == B_TYPE);
    return (info.itype == UNDEF) ||
           (info.opcode[1:0] != 2'b11) ||
           (imm12 && (info.imm[19:12] != {8{info.imm[11]}}));
  endfunction

endpackage

// File: rtl/riscv_pipe_stage.sv
// Valid/ready register slice with synchronous flush; ready is combinational
// so a full chain of slices sustains one transfer per clock.
module riscv_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_c_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  // Flush makes the slice look empty so upstream never stalls on dropped data
  assign ready_c_o = flush_i || !valid_q || ready_i;
  assign valid_o   = valid_q;
  assign data_o    = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (ready_c_o) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/riscv_insn_encoder.sv
// Two-stage RISC-V instruction encoder: S1 registers decoded fields plus a legality
// flag, S2 registers the packed word; counts delivered good and errored outputs.
module riscv_insn_encoder
  import riscv::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter bit          CHECK_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  insn_info_t        in_info,
  output logic              out_valid,
  input  logic              out_ready,
  output insn_t             out_insn,
  output logic              out_err,
  output logic [CNT_W-1:0]  cnt_ok,
  output logic [CNT_W-1:0]  cnt_err
);

  localparam int unsigned S1_W = $bits(s1_payload_t);
  localparam int unsigned S2_W = $bits(s2_payload_t);

  s1_payload_t s1_in, s1_out;
  s2_payload_t s2_in, s2_out;
  logic        s1_valid;
  logic        s2_ready;

  logic [CNT_W-1:0] cnt_ok_q,  cnt_ok_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

  always_comb begin
    s1_in.info = in_info;
    s1_in.err  = CHECK_EN ? insn_illegal(in_info) : 1'b0;
  end

  riscv_pipe_stage #(.W(S1_W)) u_s1_check (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .valid_i   (in_valid),
    .ready_c_o (in_ready),
    .data_i    (s1_in),
    .valid_o   (s1_valid),
    .ready_i   (s2_ready),
    .data_o    (s1_out)
  );

  // Errored instructions leave the pipe as an all-zero word
  always_comb begin
    s2_in.err  = s1_out.err;
    s2_in.insn = s1_out.err ? '0 : encode_insn(s1_out.info);
  end

  riscv_pipe_stage #(.W(S2_W)) u_s2_pack (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .valid_i   (s1_valid),
    .ready_c_o (s2_ready),
    .data_i    (s2_in),
    .valid_o   (out_valid),
    .ready_i   (out_ready),
    .data_o    (s2_out)
  );

  assign out_insn = s2_out.insn;
  assign out_err  = s2_out.err;

  // Output transfers are counted even in a flush cycle
  always_comb begin
    cnt_ok_d  = cnt_ok_q;
    cnt_err_d = cnt_err_q;
    if (out_valid && out_ready) begin
      if (out_err) begin
        cnt_err_d = cnt_err_q + CNT_W'(1);
      end else begin
        cnt_ok_d  = cnt_ok_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      cnt_ok_q  <= cnt_ok_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign cnt_ok  = cnt_ok_q;
  assign cnt_err = cnt_err_q;

endmodule

// File: tb/tb_riscv_insn_encoder.sv
// Scoreboard bench for riscv_insn_encoder: directed vectors with hand-computed words,
// a decoupled monitor pops expectations on every output transfer.
module tb_riscv_insn_encoder;
  import riscv::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  insn_info_t  in_info;
  logic        out_valid;
  logic        out_ready;
  insn_t       out_insn;
  logic        out_err;
  logic [15:0] cnt_ok;
  logic [15:0] cnt_err;

  always #5 clk = ~clk;

  riscv_insn_encoder #(.CNT_W(16), .CHECK_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_info   (in_info),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_insn  (out_insn),
    .out_err   (out_err),
    .cnt_ok    (cnt_ok),
    .cnt_err   (cnt_err)
  );

  typedef struct {
    insn_t insn;
    logic  err;
    int    acc_cyc;
    bit    chk_lat;
  } exp_t;

  exp_t sb[$];
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   exp_ok  = 0;
  int   exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic insn_info_t mk(input insn_type_t t, input logic [6:0] op,
                                    input logic [4:0] rd, input logic [2:0] f3,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [6:0] f7, input logic [19:0] imm);
    insn_info_t i;
    i.itype  = t;
    i.opcode = op;
    i.rd     = rd;
    i.funct3 = f3;
    i.rs1    = rs1;
    i.rs2    = rs2;
    i.funct7 = f7;
    i.imm    = imm;
    return i;
  endfunction

  // Monitor: every output transfer pops and checks one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got insn %h err %b want no output", out_insn, out_err);
        end else begin
          e = sb.pop_front();
          check("out_insn", out_insn, e.insn);
          check("out_err", 32'(out_err), 32'(e.err));
          if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
          if (e.err) exp_err++;
          else       exp_ok++;
        end
      end
    end
  end

  task automatic send(input insn_info_t info, input insn_t exp_insn, input logic exp_err_i,
                      input bit lat);
    bit   done = 1'b0;
    int   n    = 0;
    exp_t e;
    in_valid = 1'b1;
    in_info  = info;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.insn    = exp_insn;
        e.err     = exp_err_i;
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got in_ready stuck low want accept within 50 clk");
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_info   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_insn", out_insn, 32'h0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_cnt_ok", 32'(cnt_ok), 32'd0);
    check("rst_cnt_err", 32'(cnt_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic encodings with latency checks; S vector carries junk rd/funct7
    send(mk(I_TYPE, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'h00005), 32'h00500093, 1'b0, 1'b1);
    drain();
    send(mk(R_TYPE, OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 20'h0), 32'h002081B3, 1'b0, 1'b1);
    send(mk(S_TYPE, STORE, 5'h1F, 3'd2, 5'd1, 5'd2, 7'h7F, 20'h00008), 32'h0020A423, 1'b0, 1'b1);
    send(mk(B_TYPE, BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 20'hFFFFE), 32'hFE000EE3, 1'b0, 1'b1);
    send(mk(J_TYPE, JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'h00004), 32'h008000EF, 1'b0, 1'b1);
    send(mk(U_TYPE, LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 20'h12345), 32'h123452B7, 1'b0, 1'b1);
    drain();
    check("cnt_ok_basic", 32'(cnt_ok), 32'd6);
    check("cnt_err_basic", 32'(cnt_err), 32'd0);

    // Legality: immediate range edges, UNDEF, bad opcode low bits
    send(mk(I_TYPE, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'h01000), 32'h0, 1'b1, 1'b0);
    drain();
    check("cnt_err_first", 32'(cnt_err), 32'd1);
    send(mk(UNDEF, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'h00005), 32'h0, 1'b1, 1'b0);
    send(mk(I_TYPE, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'hFF800), 32'h80000093, 1'b0, 1'b0);
    send(mk(I_TYPE, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'h007FF), 32'h7FF00093, 1'b0, 1'b0);
    send(mk(I_TYPE, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'h00800), 32'h0, 1'b1, 1'b0);
    send(mk(R_TYPE, 7'h30, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 20'h0), 32'h0, 1'b1, 1'b0);
    send(mk(S_TYPE, STORE, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 20'h10000), 32'h0, 1'b1, 1'b0);
    drain();
    check("cnt_ok_err", 32'(cnt_ok), 32'd8);
    check("cnt_err_err", 32'(cnt_err), 32'd5);

    // Back-pressure: two entries fill the pipe, then in_ready must drop
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) begin
          send(mk(I_TYPE, OP_IMM, 5'(k), 3'd0, 5'd0, 5'd0, 7'd0, 20'h00005),
               32'h00500013 | (32'(k) << 7), 1'b0, 1'b0);
        end
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_held_insn", out_insn, 32'h00500093);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("cnt_ok_bp", 32'(cnt_ok), 32'd12);

    // Flush with two in flight
    out_ready = 1'b0;
    send(mk(R_TYPE, OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 20'h0), 32'h002081B3, 1'b0, 1'b0);
    send(mk(R_TYPE, OP, 5'd4, 3'd0, 5'd1, 5'd2, 7'd0, 20'h0), 32'h002082B3, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("flush_cnt_ok", 32'(cnt_ok), 32'(exp_ok));
    check("flush_cnt_err", 32'(cnt_err), 32'(exp_err));

    // Reset mid-operation drops data and clears counters
    out_ready = 1'b0;
    send(mk(I_TYPE, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'h00005), 32'h00500093, 1'b0, 1'b0);
    send(mk(I_TYPE, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'h01000), 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_ok  = 0;
    exp_err = 0;
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_cnt_ok", 32'(cnt_ok), 32'd0);
    check("rst2_cnt_err", 32'(cnt_err), 32'd0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(mk(I_TYPE, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'h00005), 32'h00500093, 1'b0, 1'b1);
    drain();
    check("post_rst_cnt_ok", 32'(cnt_ok), 32'd1);
    check("post_rst_cnt_err", 32'(cnt_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
